// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit.
//   md_func_e  : MD function codes, identical to the decoder's MDFunc field.
//   md_state_e : sequencer states (IDLE, RUN, FIX).
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE = 3'd0,
    MD_MTHI = 3'd1,
    MD_MTLO = 3'd2,
    MD_MUL  = 3'd3,
    MD_DIV  = 3'd4
  } md_func_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_iter_core.sv
// Single-step iterative datapath shared by multiply and divide.
// Ports:
//   op_div    in  1      0 = shift-add multiply step, 1 = restoring divide step
//   acc_i     in  WIDTH  partial product (mul) / partial remainder (div)
//   shreg_i   in  WIDTH  multiplier shift register (mul) / dividend->quotient (div)
//   operand_i in  WIDTH  multiplicand (mul) / divisor (div)
//   acc_o     out WIDTH  next partial product / remainder
//   shreg_o   out WIDTH  next multiplier / quotient shift register
// After WIDTH steps {acc, shreg} holds the product, or acc = remainder and
// shreg = quotient.
module md_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             op_div,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] shreg_i,
  input  logic [WIDTH-1:0] operand_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] shreg_o
);

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             take;

  always_comb begin
    // Multiply: add multiplicand when the current multiplier LSB is set, then
    // shift the whole {acc, shreg} pair right, carry included.
    add_sum = {1'b0, acc_i} + (shreg_i[0] ? {1'b0, operand_i} : '0);
    // Divide: bring the next dividend bit into the remainder and trial-subtract.
    // When the subtraction is taken the true difference is below the divisor,
    // so the low WIDTH bits are exact.
    shifted = {acc_i, shreg_i[WIDTH-1]};
    diff    = shifted[WIDTH-1:0] - operand_i;
    take    = (shifted >= {1'b0, operand_i});
    if (op_div) begin
      acc_o   = take ? diff : shifted[WIDTH-1:0];
      shreg_o = {shreg_i[WIDTH-2:0], take};
    end else begin
      acc_o   = add_sum[WIDTH:1];
      shreg_o = {add_sum[0], shreg_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide unit with HI/LO registers, sitting beside EX.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   md_valid           EX instruction valid
//   md_func [2:0]      none / mthi / mtlo / mult / div
//   md_sign            signed operation
//   rd_hilo            EX instruction reads HI or LO
//   a, b [WIDTH]       rs / rt operands
//   hi, lo [WIDTH]     architectural HI / LO
//   busy               operation in flight (RUN or FIX)
//   stall_req          hold EX and earlier this cycle
//   done               one-cycle pulse while results are written (FIX)
// Parameters: WIDTH operand width; MUL_FAST=1 finishes a multiply in a single
// RUN cycle with a combinational product.
module md_sequencer
  import md_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_FAST = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             md_valid,
  input  logic [2:0]       md_func,
  input  logic             md_sign,
  input  logic             rd_hilo,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall_req,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   core_acc, core_shreg;
  logic [2*WIDTH-1:0] fast_prod;
  logic [2*WIDTH-1:0] full_res;
  logic [2*WIDTH-1:0] mul_res;

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .op_div    (is_div_q),
    .acc_i     (acc_q),
    .shreg_i   (shreg_q),
    .operand_i (opnd_q),
    .acc_o     (core_acc),
    .shreg_o   (core_shreg)
  );

  // Magnitudes feed the unsigned iteration; sign is restored in FIX.
  // The most negative value maps onto itself, which is the correct unsigned
  // magnitude and makes the signed overflow case fall out naturally.
  assign a_mag     = (md_sign && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign b_mag     = (md_sign && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  assign fast_prod = {{WIDTH{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, shreg_q};
  assign full_res  = {acc_q, shreg_q};
  assign mul_res   = neg_quo_q ? (~full_res + (2*WIDTH)'(1)) : full_res;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      shreg_q   <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      shreg_q   <= shreg_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    shreg_d   = shreg_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      IDLE: begin
        if (md_valid) begin
          case (md_func_e'(md_func))
            MD_MTHI: hi_d = a;
            MD_MTLO: lo_d = a;
            MD_MUL, MD_DIV: begin
              is_div_d  = (md_func_e'(md_func) == MD_DIV);
              // A zero divisor yields an all-ones quotient from the iteration;
              // suppressing quotient negation keeps it all ones for signed ops,
              // while remainder negation turns |a| back into a.
              neg_quo_d = md_sign & (a[WIDTH-1] ^ b[WIDTH-1])
                          & ~(is_div_d & (b == '0));
              neg_rem_d = md_sign & a[WIDTH-1];
              acc_d     = '0;
              cnt_d     = CNT_W'(WIDTH - 1);
              if (is_div_d) begin
                shreg_d = a_mag;
                opnd_d  = b_mag;
              end else begin
                shreg_d = b_mag;
                opnd_d  = a_mag;
              end
              state_d = RUN;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        if (MUL_FAST != 0 && !is_div_q) begin
          {acc_d, shreg_d} = fast_prod;
          state_d          = FIX;
        end else begin
          acc_d   = core_acc;
          shreg_d = core_shreg;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == '0) state_d = FIX;
        end
      end
      FIX: begin
        if (is_div_q) begin
          lo_d = neg_quo_q ? (~shreg_q + WIDTH'(1)) : shreg_q;
          hi_d = neg_rem_q ? (~acc_q + WIDTH'(1)) : acc_q;
        end else begin
          {hi_d, lo_d} = mul_res;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIX);
  assign stall_req = busy & md_valid & ((md_func != 3'd0) | rd_hilo);

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: a table of mult/div vectors with
// hand-computed HI/LO, plus hand-written sequences for mthi/mtlo, mfhi stall,
// mid-operation reset, back-to-back issue and the MUL_FAST variant.
module tb_md_sequencer;
  import md_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         md_valid;
  logic [2:0]   md_func;
  logic         md_sign;
  logic         rd_hilo;
  logic [W-1:0] a, b;

  logic [W-1:0] hi, lo, hi_f, lo_f;
  logic         busy, stall_req, done;
  logic         busy_f, stall_f, done_f;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  md_sequencer #(.WIDTH(W), .MUL_FAST(0)) dut (
    .clk(clk), .reset(reset), .md_valid(md_valid), .md_func(md_func),
    .md_sign(md_sign), .rd_hilo(rd_hilo), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .stall_req(stall_req), .done(done)
  );

  md_sequencer #(.WIDTH(W), .MUL_FAST(1)) dut_fast (
    .clk(clk), .reset(reset), .md_valid(md_valid), .md_func(md_func),
    .md_sign(md_sign), .rd_hilo(rd_hilo), .a(a), .b(b),
    .hi(hi_f), .lo(lo_f), .busy(busy_f), .stall_req(stall_f), .done(done_f)
  );

  typedef struct {
    logic [2:0]   func;
    logic         sign;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Present an instruction for exactly one cycle, then scramble the operands
  // so any late sampling shows up in the result.
  task automatic applyStimulus(input logic [2:0] func, input logic sign,
                               input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    md_valid = 1'b1; md_func = func; md_sign = sign; a = av; b = bv;
    @(negedge clk);
    md_valid = 1'b0; md_func = 3'd0; md_sign = ~sign;
    a = $urandom; b = $urandom;
  endtask

  // Count busy and done cycles of the reference instance until it goes idle.
  task automatic runToDone(output int busy_cycles, output int done_cycles);
    int guard;
    busy_cycles = 0; done_cycles = 0; guard = 0;
    while (busy && guard < 200) begin
      busy_cycles++;
      if (done) done_cycles++;
      guard++;
      @(negedge clk);
    end
    if (busy) checkOutput("timeout_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bc, dc, guard, nstall, ndone;

    vecs[0] = '{3'd3, 1'b0, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
    vecs[1] = '{3'd3, 1'b1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2] = '{3'd4, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{3'd4, 1'b0, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vecs[4] = '{3'd4, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{3'd4, 1'b1, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[6] = '{3'd4, 1'b0, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[7] = '{3'd3, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8] = '{3'd3, 1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[9] = '{3'd4, 1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};

    // Reset has priority over an mthi presented at the same time.
    reset = 1'b1; md_valid = 1'b1; md_func = 3'd1; md_sign = 1'b0;
    rd_hilo = 1'b0; a = 32'hDEAD; b = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_hi", 64'(hi), 64'd0);
    checkOutput("reset_lo", 64'(lo), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_stall", 64'(stall_req), 64'd0);
    reset = 1'b0; md_valid = 1'b0; md_func = 3'd0;

    // mthi / mtlo while idle.
    applyStimulus(3'd1, 1'b0, 32'h1234, 32'h0);
    checkOutput("mthi_hi", 64'(hi), 64'h1234);
    checkOutput("mthi_busy", 64'(busy), 64'd0);
    applyStimulus(3'd2, 1'b0, 32'h5678, 32'h0);
    checkOutput("mtlo_lo", 64'(lo), 64'h5678);
    checkOutput("mtlo_hi_kept", 64'(hi), 64'h1234);

    // MUL_FAST instance: signed -3 * 5 in two busy cycles.
    applyStimulus(3'd3, 1'b1, 32'hFFFFFFFD, 32'd5);
    bc = 0; guard = 0;
    while (busy_f && guard < 50) begin bc++; guard++; @(negedge clk); end
    checkOutput("fast_busy_cycles", 64'(bc), 64'd2);
    checkOutput("fast_hi", 64'(hi_f), 64'hFFFFFFFF);
    checkOutput("fast_lo", 64'(lo_f), 64'hFFFFFFF1);
    runToDone(bc, dc);

    // Table of multiply / divide vectors.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].func, vecs[i].sign, vecs[i].av, vecs[i].bv);
      runToDone(bc, dc);
      checkOutput($sformatf("vec%0d_busy", i), 64'(bc), 64'd33);
      checkOutput($sformatf("vec%0d_done", i), 64'(dc), 64'd1);
      checkOutput($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
      checkOutput($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
    end

    // mfhi held in EX during a divide: stalled through FIX, released after.
    applyStimulus(3'd4, 1'b0, 32'd100, 32'd7);
    md_valid = 1'b1; rd_hilo = 1'b1; md_func = 3'd0;
    nstall = 0; bc = 0; guard = 0;
    while (busy && guard < 200) begin
      bc++;
      if (stall_req) nstall++;
      guard++;
      @(negedge clk);
    end
    checkOutput("mfhi_stall_cycles", 64'(nstall), 64'd33);
    checkOutput("mfhi_stall_cleared", 64'(stall_req), 64'd0);
    checkOutput("mfhi_hi", 64'(hi), 64'd2);
    md_valid = 1'b0; rd_hilo = 1'b0;

    // Reset 10 cycles into a multiply aborts it without a done pulse.
    applyStimulus(3'd3, 1'b0, 32'd1000, 32'd1000);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_hi", 64'(hi), 64'd0);
    checkOutput("abort_lo", 64'(lo), 64'd0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    checkOutput("abort_no_done", 64'(ndone), 64'd0);
    applyStimulus(3'd3, 1'b0, 32'd6, 32'd7);
    runToDone(bc, dc);
    checkOutput("after_abort_lo", 64'(lo), 64'd42);
    checkOutput("after_abort_hi", 64'(hi), 64'd0);

    // Back-to-back: second mult waits in EX through FIX of the first.
    applyStimulus(3'd3, 1'b0, 32'd3, 32'd4);
    md_valid = 1'b1; md_func = 3'd3; md_sign = 1'b1;
    a = 32'hFFFFFFFB; b = 32'd6;
    guard = 0;
    while (busy && guard < 200) begin
      if (done) checkOutput("b2b_stall_in_fix", 64'(stall_req), 64'd1);
      guard++;
      @(negedge clk);
    end
    checkOutput("b2b_first_hi", 64'(hi), 64'd0);
    checkOutput("b2b_first_lo", 64'(lo), 64'd12);
    checkOutput("b2b_idle_stall", 64'(stall_req), 64'd0);
    @(negedge clk);
    md_valid = 1'b0; md_func = 3'd0; a = $urandom; b = $urandom;
    checkOutput("b2b_second_accepted", 64'(busy), 64'd1);
    runToDone(bc, dc);
    checkOutput("b2b_second_busy", 64'(bc), 64'd33);
    checkOutput("b2b_second_hi", 64'(hi), 64'hFFFFFFFF);
    checkOutput("b2b_second_lo", 64'(lo), 64'hFFFFFFE2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
